bullet_pool: RTL and testbench
==============================

Name: bullet_pool

Overview:
- Parametrised multi-bullet generator that replaces the single-bullet block.
- Owns N_BULLETS independent bullet slots. Each slot spawns above the player on a fire request, climbs the screen one step per clk_en tick, and retires when it reaches the top, on a hit, or when the game leaves the play scene.
- Adds a fire cooldown, slot allocation, per-slot hit clearing and status pulses.
- Its outputs feed the renderer and the collision checker.

Parameters:
N_BULLETS, 4, number of bullet slots (1..8)
COORD_W, 9, coordinate width in bits
Y_IDLE, 300, Y value of an idle (off-screen) slot
Y_SPAWN, 215, Y loaded on spawn
X_OFFSET, 7, added to player_X on spawn
STEP, 1, pixels climbed per clk_en tick (1..15)
COOLDOWN, 8, clk_en ticks after a fire during which new fires are refused (0 = no cooldown)
SCENE_PLAY, 2'd1, scene code in which bullets live

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clk_en  in  1  movement tick, one clk wide
swF_re  in  1  fire-button rising-edge pulse
hit  in  N_BULLETS  per-slot hit from the collision checker
scene  in  2  current game scene
player_X  in  COORD_W  player left edge
X  out  N_BULLETS*COORD_W  packed slot X; slot i occupies bits [i*COORD_W +: COORD_W]
Y  out  N_BULLETS*COORD_W  packed slot Y, same packing
active  out  N_BULLETS  slot i is in flight
fired  out  1  one-clk pulse: a fire was accepted
fire_drop  out  1  one-clk pulse: a fire was refused

Behaviour:
- Reset (async assert, sync release): every slot X=0, Y=Y_IDLE, active=0; cooldown counter=0; fired=0; fire_drop=0.
- All state is registered. Every output is a register, updated on the clk edge after the causing input, so latency is 1 clk.
- Slot state is idle or flying; active reflects flying.

Priority per slot each clk, highest first:
1. scene!=SCENE_PLAY: slot goes idle (Y=Y_IDLE, X held).
2. hit[i] while flying: slot goes idle. hit[i] on an idle slot is ignored.
3. Flying and clk_en:
   - if Y<=STEP: slot goes idle (top reached);
   - else Y<=Y-STEP.
4. Spawn, if this slot is the allocated one: X=sat(player_X+X_OFFSET), Y=Y_SPAWN, goes flying.
   - sat() clamps to 2^COORD_W-1 on overflow.

Fire acceptance:
- Conditions: swF_re=1, scene==SCENE_PLAY, cooldown==0, and at least one slot idle at the start of the cycle.
- Allocation: lowest-index slot idle at the start of the cycle. A slot freed by hit or top-reach in the same cycle is not reusable until the next cycle.
- Accepted fire: spawn, fired=1, cooldown=COOLDOWN. The new bullet does not move on its spawn cycle even if clk_en=1.
- swF_re=1 with any condition failing: fire_drop=1, no state change. Exception: outside the play scene swF_re is ignored and neither pulse fires.

Cooldown:
- Decrements by 1 on each clk_en while nonzero; saturates at 0.
- A fire accepted in the same cycle as clk_en reloads COOLDOWN (the reload wins).
- Leaving SCENE_PLAY clears cooldown to 0.

Other rules:
- Y arithmetic is unsigned COORD_W; Y never wraps below 0, because of the Y<=STEP retire rule.
- Mid-operation reset returns every slot to idle immediately, with no partial state retained.

Test Plan:
1. Reset release, scene=1, no inputs -> all active=0, every Y=300, every X=0, fired=0.
2. player_X=100, swF_re pulse -> next clk slot0 X=107, Y=215, active=4'b0001, fired=1. Then 10 clk_en ticks -> slot0 Y=205. Tick 215 -> slot0 idle, Y=300.
3. COOLDOWN=8: fire, then swF_re after 3 clk_en ticks -> fire_drop=1, slot1 stays idle. swF_re after 8 ticks total -> slot1 spawns, fired=1.
4. COOLDOWN=0: 4 fires -> active=4'b1111. 5th fire -> fire_drop=1. hit=4'b0100 -> slot2 idle next clk. Fire in the same cycle as that hit -> fire_drop; fire one cycle later -> slot2 respawns.
5. Two slots flying, scene changes 1->0 -> next clk all active=0, Y=300, cooldown=0. swF_re while scene=0 -> no fired and no fire_drop.
6. Edge cases:
   - player_X=510 with X_OFFSET=7 -> X=511 (saturated).
   - STEP=4 with Y reaching 4 -> retires on that tick, never 0 or wrapped.
   - rst_n low mid-flight -> immediate idle.

Source files
------------

// File: rtl/bullet_pool.sv
// Multi-slot bullet generator: fire allocation, cooldown, per-slot climb/retire and hit clearing.
// Latency: every output is a register updated one clk after the causing input.
// No backpressure; refused fires are reported with a one-clk fire_drop pulse.
module bullet_pool #(
    parameter int          N_BULLETS  = 4,
    parameter int          COORD_W    = 9,
    parameter int          Y_IDLE     = 300,
    parameter int          Y_SPAWN    = 215,
    parameter int          X_OFFSET   = 7,
    parameter int          STEP       = 1,
    parameter int          COOLDOWN   = 8,
    parameter logic [1:0]  SCENE_PLAY = 2'd1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clk_en,
    input  logic                           swF_re,
    input  logic [N_BULLETS-1:0]           hit,
    input  logic [1:0]                     scene,
    input  logic [COORD_W-1:0]             player_X,
    output logic [N_BULLETS*COORD_W-1:0]   X,
    output logic [N_BULLETS*COORD_W-1:0]   Y,
    output logic [N_BULLETS-1:0]           active,
    output logic                           fired,
    output logic                           fire_drop
);

    localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [COORD_W-1:0] Y_IDLE_C  = COORD_W'(Y_IDLE);
    localparam logic [COORD_W-1:0] Y_SPAWN_C = COORD_W'(Y_SPAWN);
    localparam logic [COORD_W-1:0] STEP_C    = COORD_W'(STEP);

    logic [COORD_W-1:0]   x_q [N_BULLETS];
    logic [COORD_W-1:0]   y_q [N_BULLETS];
    logic [N_BULLETS-1:0] act_q;
    logic [CD_W-1:0]      cd_q;
    logic                 fired_q;
    logic                 drop_q;

    logic                 play;
    logic                 accept;
    logic [N_BULLETS-1:0] idle;
    logic [N_BULLETS-1:0] alloc_oh;
    logic [COORD_W:0]     x_sum;
    logic [COORD_W-1:0]   spawn_x;

    assign play     = (scene == SCENE_PLAY);
    assign idle     = ~act_q;
    // Lowest set bit of the idle mask picks the slot; based on start-of-cycle state only.
    assign alloc_oh = idle & (~idle + N_BULLETS'(1));
    assign accept   = swF_re && play && (cd_q == '0) && (idle != '0);
    assign x_sum    = {1'b0, player_X} + (COORD_W + 1)'(X_OFFSET);
    assign spawn_x  = x_sum[COORD_W] ? {COORD_W{1'b1}} : x_sum[COORD_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BULLETS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= Y_IDLE_C;
            end
            act_q   <= '0;
            cd_q    <= '0;
            fired_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            fired_q <= accept;
            drop_q  <= swF_re && play && !accept;

            if (!play)
                cd_q <= '0;
            else if (accept)
                cd_q <= CD_W'(COOLDOWN);
            else if (clk_en && (cd_q != '0))
                cd_q <= cd_q - CD_W'(1);

            for (int i = 0; i < N_BULLETS; i++) begin
                if (!play) begin
                    act_q[i] <= 1'b0;
                    y_q[i]   <= Y_IDLE_C;
                end else if (hit[i] && act_q[i]) begin
                    act_q[i] <= 1'b0;
                    y_q[i]   <= Y_IDLE_C;
                end else if (act_q[i] && clk_en) begin
                    // Retire before subtracting so Y can never wrap below zero.
                    if (y_q[i] <= STEP_C) begin
                        act_q[i] <= 1'b0;
                        y_q[i]   <= Y_IDLE_C;
                    end else begin
                        y_q[i] <= y_q[i] - STEP_C;
                    end
                end else if (accept && alloc_oh[i]) begin
                    act_q[i] <= 1'b1;
                    x_q[i]   <= spawn_x;
                    y_q[i]   <= Y_SPAWN_C;
                end
            end
        end
    end

    for (genvar g = 0; g < N_BULLETS; g++) begin : g_pack
        assign X[g*COORD_W +: COORD_W] = x_q[g];
        assign Y[g*COORD_W +: COORD_W] = y_q[g];
    end

    assign active    = act_q;
    assign fired     = fired_q;
    assign fire_drop = drop_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench for bullet_pool: stimulus queues hand-computed expectations per cycle,
// a monitor pops and compares them just after each clock edge.
module tb_bullet_pool;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        sw_a;
    logic        sw_b;
    logic [3:0]  hit;
    logic [1:0]  scene;
    logic [8:0]  player_X;

    logic [35:0] xa, ya, xb, yb;
    logic [3:0]  act_a, act_b;
    logic        fired_a, drop_a, fired_b, drop_b;

    // Default configuration.
    bullet_pool u_a (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .swF_re(sw_a), .hit(hit),
        .scene(scene), .player_X(player_X), .X(xa), .Y(ya), .active(act_a),
        .fired(fired_a), .fire_drop(drop_a)
    );

    // No cooldown, STEP=4, spawn at 216 so Y passes exactly through 8 and 4.
    bullet_pool #(.STEP(4), .COOLDOWN(0), .Y_SPAWN(216)) u_b (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .swF_re(sw_b), .hit(hit),
        .scene(scene), .player_X(player_X), .X(xb), .Y(yb), .active(act_b),
        .fired(fired_b), .fire_drop(drop_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        int    d;
        int    s;
        int    i;
        int    v;
        string nm;
    } ent_t;

    ent_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam int S_ACT = 0, S_FIRED = 1, S_DROP = 2, S_X = 3, S_Y = 4;

    function automatic int get(input int d, input int s, input int i);
        logic [35:0] xs, ys;
        xs = (d != 0) ? xb : xa;
        ys = (d != 0) ? yb : ya;
        case (s)
            S_ACT:   return (d != 0) ? int'(act_b) : int'(act_a);
            S_FIRED: return (d != 0) ? int'(fired_b) : int'(fired_a);
            S_DROP:  return (d != 0) ? int'(drop_b) : int'(drop_a);
            S_X:     return int'(xs[i*9 +: 9]);
            default: return int'(ys[i*9 +: 9]);
        endcase
    endfunction

    // Expectation for the state right after the next rising edge.
    task automatic ex(input int d, input int s, input int i, input int v, input string nm);
        ent_t e;
        e.cyc = cyc + 1; e.d = d; e.s = s; e.i = i; e.v = v; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic drive(input logic ce, input logic sa, input logic sbv, input logic [3:0] h);
        clk_en = ce;
        sw_a   = sa;
        sw_b   = sbv;
        hit    = h;
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            ent_t e;
            int   got;
            e   = sb.pop_front();
            got = get(e.d, e.s, e.i);
            n_cmp++;
            if (e.cyc != cyc || got != e.v) begin
                n_bad++;
                $display("FAIL %s: got %0d, want %0d (cycle %0d)", e.nm, got, e.v, cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; scene = 2'd1; player_X = 9'd0;
        drive(0, 0, 0, 4'b0000);
        repeat (3) adv();
        rst_n = 1'b1;

        // Reset state
        drive(0, 0, 0, 4'b0000);
        ex(0, S_ACT, 0, 0, "rst_active");
        for (int k = 0; k < 4; k++) begin
            ex(0, S_Y, k, 300, "rst_y");
            ex(0, S_X, k, 0, "rst_x");
        end
        ex(0, S_FIRED, 0, 0, "rst_fired");
        ex(0, S_DROP, 0, 0, "rst_drop");
        ex(1, S_ACT, 0, 0, "rst_active_b");
        adv();

        // First fire and full climb to the top
        player_X = 9'd100;
        drive(0, 1, 0, 4'b0000);
        ex(0, S_X, 0, 107, "spawn_x0");
        ex(0, S_Y, 0, 215, "spawn_y0");
        ex(0, S_ACT, 0, 1, "spawn_active");
        ex(0, S_FIRED, 0, 1, "spawn_fired");
        adv();
        drive(0, 0, 0, 4'b0000);
        ex(0, S_FIRED, 0, 0, "fired_pulse_end");
        ex(0, S_ACT, 0, 1, "still_flying");
        adv();
        for (int k = 1; k <= 215; k++) begin
            drive(1, 0, 0, 4'b0000);
            if (k == 10)  ex(0, S_Y, 0, 205, "climb_10");
            if (k == 214) begin
                ex(0, S_Y, 0, 1, "climb_214");
                ex(0, S_ACT, 0, 1, "active_at_y1");
            end
            if (k == 215) begin
                ex(0, S_Y, 0, 300, "top_retire_y");
                ex(0, S_ACT, 0, 0, "top_retire_active");
            end
            adv();
        end

        // Cooldown window
        drive(0, 1, 0, 4'b0000);
        ex(0, S_FIRED, 0, 1, "cd_fire");
        ex(0, S_ACT, 0, 1, "cd_fire_active");
        adv();
        repeat (3) begin drive(1, 0, 0, 4'b0000); adv(); end
        drive(0, 1, 0, 4'b0000);
        ex(0, S_DROP, 0, 1, "cd_drop_3");
        ex(0, S_FIRED, 0, 0, "cd_nofire_3");
        ex(0, S_ACT, 0, 1, "cd_slot1_idle");
        adv();
        repeat (4) begin drive(1, 0, 0, 4'b0000); adv(); end
        drive(0, 1, 0, 4'b0000);
        ex(0, S_DROP, 0, 1, "cd_drop_7");
        adv();
        drive(1, 0, 0, 4'b0000);
        adv();
        drive(1, 1, 0, 4'b0000);
        ex(0, S_FIRED, 0, 1, "cd_fire_8");
        ex(0, S_ACT, 0, 3, "cd_two_active");
        ex(0, S_Y, 0, 206, "cd_slot0_moved");
        ex(0, S_Y, 1, 215, "spawn_no_move");
        ex(0, S_X, 1, 107, "slot1_x");
        adv();
        repeat (7) begin drive(1, 0, 0, 4'b0000); adv(); end
        drive(0, 1, 0, 4'b0000);
        ex(0, S_DROP, 0, 1, "reload_wins");
        ex(0, S_Y, 1, 208, "slot1_y_after7");
        adv();

        // Scene exit
        scene = 2'd0;
        drive(0, 0, 0, 4'b0000);
        ex(0, S_ACT, 0, 0, "scene_idle");
        ex(0, S_Y, 0, 300, "scene_y0");
        ex(0, S_Y, 1, 300, "scene_y1");
        ex(0, S_X, 1, 107, "scene_x_held");
        adv();
        drive(0, 1, 0, 4'b0000);
        ex(0, S_FIRED, 0, 0, "scene0_no_fired");
        ex(0, S_DROP, 0, 0, "scene0_no_drop");
        ex(0, S_ACT, 0, 0, "scene0_no_spawn");
        adv();
        scene = 2'd1;
        drive(0, 1, 0, 4'b0000);
        ex(0, S_FIRED, 0, 1, "cd_cleared_fire");
        ex(0, S_ACT, 0, 1, "cd_cleared_active");
        adv();

        // X saturation
        repeat (8) begin drive(1, 0, 0, 4'b0000); adv(); end
        player_X = 9'd510;
        drive(0, 1, 0, 4'b0000);
        ex(0, S_X, 1, 511, "x_saturated");
        ex(0, S_ACT, 0, 3, "sat_active");
        adv();

        // Mid-flight reset
        drive(1, 0, 0, 4'b0000);
        rst_n = 1'b0;
        ex(0, S_ACT, 0, 0, "midrst_active");
        ex(0, S_Y, 0, 300, "midrst_y0");
        ex(0, S_Y, 1, 300, "midrst_y1");
        ex(0, S_X, 1, 0, "midrst_x1");
        adv();
        rst_n = 1'b1;

        // No cooldown: fill every slot, overflow, hit and respawn
        player_X = 9'd20;
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1, 4'b0000);
            ex(1, S_ACT, 0, (2 << k) - 1, "fill_active");
            ex(1, S_FIRED, 0, 1, "fill_fired");
            adv();
        end
        drive(0, 0, 1, 4'b0000);
        ex(1, S_DROP, 0, 1, "full_drop");
        ex(1, S_FIRED, 0, 0, "full_nofire");
        ex(1, S_ACT, 0, 15, "full_active");
        adv();
        drive(0, 0, 1, 4'b0100);
        ex(1, S_ACT, 0, 11, "hit_slot2");
        ex(1, S_DROP, 0, 1, "hit_same_cycle_drop");
        ex(1, S_FIRED, 0, 0, "hit_same_cycle_nofire");
        ex(0, S_ACT, 0, 0, "hit_idle_ignored");
        adv();
        drive(0, 0, 1, 4'b0000);
        ex(1, S_ACT, 0, 15, "respawn_active");
        ex(1, S_FIRED, 0, 1, "respawn_fired");
        ex(1, S_Y, 2, 216, "respawn_y2");
        ex(1, S_X, 2, 27, "respawn_x2");
        adv();

        // STEP=4 retire boundary
        for (int k = 1; k <= 54; k++) begin
            drive(1, 0, 0, 4'b0000);
            if (k == 52) ex(1, S_Y, 0, 8, "step4_y8");
            if (k == 53) begin
                ex(1, S_Y, 0, 4, "step4_y4");
                ex(1, S_ACT, 0, 15, "step4_active_at4");
            end
            if (k == 54) begin
                ex(1, S_Y, 0, 300, "step4_retire_y0");
                ex(1, S_Y, 2, 300, "step4_retire_y2");
                ex(1, S_ACT, 0, 0, "step4_retire_active");
            end
            adv();
        end

        drive(0, 0, 0, 4'b0000);
        adv();
        adv();
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
            n_cmp += sb.size();
            n_bad += sb.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
